multi_clk_divider: RTL
======================

// Module: multi_clk_divider
// PURPOSE
//  Parametrised N-channel clock divider. Each channel is runtime-programmable for period and high time.
//  Ratio updates are shadowed and applied only at a period boundary, so output edges never glitch.
//  A global sync strobe phase-aligns all channels.
//  Feeds sensor/pixel-rate logic and strobe timing in the eye-tracker pipeline. Per-channel tick enables are
//  provided for logic that must stay on CLK.
// PARAMETERS
//  NUM_CH   4  number of independent divider channels (1..16)
//  CNT_W    8  width of period/high-time fields and counters; max period 2**CNT_W-1
//  DEF_DIV  8  period applied to every channel at reset (2..2**CNT_W-1)
//  DEF_HI   4  high time applied to every channel at reset (0..DEF_DIV)
// PORTS
//  CLK        in   1                source clock
//  RST        in   1                asynchronous, active-high reset
//  iWR        in   1                write strobe for shadow registers
//  iWR_CH     in   $clog2(NUM_CH)   channel written; values >= NUM_CH are ignored
//  iWR_DIV    in   CNT_W            new period in CLK cycles
//  iWR_HI     in   CNT_W            new high time in CLK cycles
//  iEN        in   NUM_CH           per-channel run enable
//  iSYNC      in   1                one-cycle strobe: restart all channels at period start
//  oDIV_CLK   out  NUM_CH           divided clocks, registered
//  oTICK      out  NUM_CH           one-cycle pulse at the first cycle of each period
//  oPENDING   out  NUM_CH           shadow written but not yet applied
// BEHAVIOUR
//  - Reset values: oDIV_CLK=0, oTICK=0, oPENDING=0. Counters=0, active and shadow DIV/HI = DEF_DIV/DEF_HI.
//    Reset mid-operation aborts immediately with no pending carry-over.
//  - Per-channel states: IDLE (iEN=0 or active DIV=0) and RUN. All outputs are registered.
//  - RUN: counter counts 0..DIV-1, then wraps.
//    - The output cycle corresponding to count 0 has oTICK=1.
//    - oDIV_CLK=1 for count < HI, else 0.
//    - HI=0 gives constant 0; HI>=DIV gives constant 1.
//    - Example: DIV=8, HI=4 gives 50% duty at CLK/8.
//  - DIV=1: oTICK=1 every cycle; oDIV_CLK follows the HI rule (HI>=1 gives 1).
//  - Write: iWR with a valid iWR_CH loads that channel's shadow and sets oPENDING next cycle.
//    A second write while pending overwrites the shadow; only the last value is applied.
//  - Apply: the shadow is copied to active on the wrap cycle (count DIV-1 -> 0).
//    In IDLE it is applied on the next cycle. oPENDING clears in the cycle the new period starts.
//  - Write on the same cycle as the wrap: the write is not applied at that wrap; it waits one full new period.
//  - IDLE -> RUN (iEN rises): the counter starts at 0, so oTICK occurs 1 cycle after iEN is sampled high.
//  - RUN -> IDLE (iEN falls): the channel finishes its current period, then holds oDIV_CLK=0 and the counter at 0.
//    A period already low therefore never produces a runt pulse.
//  - iSYNC: on the next cycle every running channel applies any pending shadow and restarts at count 0.
//    All oTICK are coincident.
//  - iSYNC has priority over a simultaneous wrap; iWR on the same cycle as iSYNC is not applied by that sync.
//    Truncated periods are accepted on sync; this is the only permitted non-boundary restart.
//  - Counter width is CNT_W. Comparisons are unsigned, with no overflow, since count < DIV <= 2**CNT_W-1.
// CONFIGURATION
//  DIV_BUFG_EN defined: each oDIV_CLK bit is driven through a BUFG primitive for clock-net use.
//  DIV_BUFG_EN undefined: oDIV_CLK is the flop output directly, usable as data or enable only.
//  oTICK is unaffected by the macro.
// STRUCTURE
//  Package div_pkg: DIV_MAX_CH, the channel-index width function, and the reset defaults
//  (DEF_DIV/DEF_HI localparams) shared with the register-map block.
//  Sub-module div_channel: one instance per channel via generate.
//  - div_channel contains the counter, active/shadow registers, IDLE/RUN state, and output flops.
//  - The top level holds only write decode, sync fan-out and the optional BUFG.
// TESTING
//  1. Reset, iEN=all 1, defaults: oDIV_CLK period 8, high 4 cycles;
//     oTICK every 8 cycles, first tick 1 cycle after reset release.
//  2. Write ch1 DIV=5, HI=2 mid-period: old period completes, then 5-cycle period with 2 high.
//     oPENDING high from write+1 until the new period starts.
//  3. Two writes to ch0 before the boundary (DIV=3, then DIV=6): only DIV=6 is applied; no runt or glitch.
//  4. Channels at DIV 3/5/7, assert iSYNC: all oTICK coincide on the next cycle; pending shadows are applied.
//  5. Drop iEN on ch2 while high: the period completes, then oDIV_CLK=0.
//     Re-enable: tick 1 cycle after, with no glitch.
//  6. Edge values: HI=0 gives constant 0; HI=DIV gives constant 1; DIV=1 ticks every cycle; DIV=0 idles.
//     iWR_CH=NUM_CH is ignored. Assert RST mid-period: all outputs go 0 asynchronously.

Source files
------------

// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
//  Definitions shared by the multi-channel clock divider and the
//  register-map block that programs it.
//  - DIV_MAX_CH : largest supported channel count
//  - ch_idx_w() : width of a channel-index field (at least 1 bit)
//  - DEF_DIV / DEF_HI : period and high time loaded into every channel at reset
//  - ch_state_e : per-channel run state
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_MAX_CH = 16;

    localparam int DEF_DIV = 8;
    localparam int DEF_HI  = 4;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

    // A single-channel build still needs a 1-bit index port.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage : div_pkg

// File: rtl/div_channel.sv
// ---------------------------------------------------------------------------
// div_channel
//  One divider channel: period counter, active and shadow period/high-time
//  registers, IDLE/RUN state and registered outputs.
//  A period runs count 0..DIV-1. Shadow values are copied to the active set
//  only at a period boundary (the wrap, a sync restart, or any cycle while
//  idle), so the output never shows a partial high or low phase.
// Ports
//  CLK       in   source clock
//  RST       in   asynchronous, active-high reset
//  iWR       in   load shadow registers from iWR_DIV/iWR_HI
//  iWR_DIV   in   new period (CNT_W)
//  iWR_HI    in   new high time (CNT_W)
//  iEN       in   run enable, sampled at each period boundary
//  iSYNC     in   restart at count 0 on the next cycle
//  oDIV_CLK  out  divided clock, registered
//  oTICK     out  pulse on the first cycle of each period, registered
//  oPENDING  out  shadow holds values not yet applied
// ---------------------------------------------------------------------------
module div_channel
    import div_pkg::ch_state_e;
    import div_pkg::CH_IDLE;
    import div_pkg::CH_RUN;
#(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 8,
    parameter int DEF_HI  = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             iWR,
    input  logic [CNT_W-1:0] iWR_DIV,
    input  logic [CNT_W-1:0] iWR_HI,
    input  logic             iEN,
    input  logic             iSYNC,
    output logic             oDIV_CLK,
    output logic             oTICK,
    output logic             oPENDING
);

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] RST_HI  = CNT_W'(DEF_HI);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    ch_state_e        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] act_div_reg, act_div_next;
    logic [CNT_W-1:0] act_hi_reg, act_hi_next;
    logic [CNT_W-1:0] shd_div_reg, shd_div_next;
    logic [CNT_W-1:0] shd_hi_reg, shd_hi_next;
    logic             pending_reg, pending_next;
    logic             tick_reg, tick_next;
    logic             div_clk_reg, div_clk_next;

    logic             boundary;
    logic [CNT_W-1:0] eff_div;
    logic [CNT_W-1:0] eff_hi;

    // State register (also holds the registered outputs)
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg   <= CH_IDLE;
            cnt_reg     <= '0;
            act_div_reg <= RST_DIV;
            act_hi_reg  <= RST_HI;
            shd_div_reg <= RST_DIV;
            shd_hi_reg  <= RST_HI;
            pending_reg <= 1'b0;
            tick_reg    <= 1'b0;
            div_clk_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            act_div_reg <= act_div_next;
            act_hi_reg  <= act_hi_next;
            shd_div_reg <= shd_div_next;
            shd_hi_reg  <= shd_hi_next;
            pending_reg <= pending_next;
            tick_reg    <= tick_next;
            div_clk_reg <= div_clk_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        act_div_next = act_div_reg;
        act_hi_next  = act_hi_reg;
        shd_div_next = shd_div_reg;
        shd_hi_next  = shd_hi_reg;
        pending_next = pending_reg;

        // An idle channel is at a boundary every cycle. While running,
        // act_div_reg is never 0, so DIV-1 cannot underflow.
        boundary = (state_reg == CH_IDLE) || iSYNC ||
                   (cnt_reg == (act_div_reg - ONE));

        // Values in force for the period that starts at this boundary.
        eff_div = pending_reg ? shd_div_reg : act_div_reg;
        eff_hi  = pending_reg ? shd_hi_reg  : act_hi_reg;

        if (boundary) begin
            act_div_next = eff_div;
            act_hi_next  = eff_hi;
            pending_next = 1'b0;
            cnt_next     = '0;
            // iEN is only honoured here, so a dropped enable lets the
            // current period finish and never produces a runt pulse.
            state_next   = (iEN && (eff_div != '0)) ? CH_RUN : CH_IDLE;
        end else begin
            cnt_next     = cnt_reg + ONE;
        end

        // A write lands in the shadow after the boundary decision above,
        // so a write on a wrap/sync cycle waits for the following boundary.
        if (iWR) begin
            shd_div_next = iWR_DIV;
            shd_hi_next  = iWR_HI;
            pending_next = 1'b1;
        end
    end

    // Output logic: computed from the next state so the flops show the
    // cycle the counter is entering.
    always_comb begin
        tick_next    = (state_next == CH_RUN) && (cnt_next == '0);
        div_clk_next = (state_next == CH_RUN) && (cnt_next < act_hi_next);
    end

    assign oDIV_CLK = div_clk_reg;
    assign oTICK    = tick_reg;
    assign oPENDING = pending_reg;

endmodule : div_channel

// File: rtl/multi_clk_divider.sv
// ---------------------------------------------------------------------------
// multi_clk_divider
//  N-channel programmable clock divider. Each channel has a runtime period
//  (DIV) and high time (HI); updates are shadowed and applied on a period
//  boundary. iSYNC restarts every channel at count 0 together.
//  This level only decodes writes, fans out sync and optionally buffers the
//  divided clocks.
// Configuration macro
//  DIV_BUFG_EN : when defined, every oDIV_CLK bit is driven through a BUFG so
//                it can be routed on a clock net. When undefined the flop
//                output drives oDIV_CLK directly (data/enable use only).
//                oTICK is never buffered.
// Ports
//  CLK       in   1        source clock
//  RST       in   1        asynchronous, active-high reset
//  iWR       in   1        shadow-register write strobe
//  iWR_CH    in   CH_W     channel written; indices >= NUM_CH are ignored
//  iWR_DIV   in   CNT_W    new period in CLK cycles
//  iWR_HI    in   CNT_W    new high time in CLK cycles
//  iEN       in   NUM_CH   per-channel run enable
//  iSYNC     in   1        one-cycle restart strobe
//  oDIV_CLK  out  NUM_CH   divided clocks, registered
//  oTICK     out  NUM_CH   first-cycle-of-period pulses
//  oPENDING  out  NUM_CH   shadow written but not yet applied
// NUM_CH is expected in 1..div_pkg::DIV_MAX_CH.
// ---------------------------------------------------------------------------
module multi_clk_divider
    import div_pkg::ch_idx_w;
#(
    parameter int  NUM_CH  = 4,
    parameter int  CNT_W   = 8,
    parameter int  DEF_DIV = div_pkg::DEF_DIV,
    parameter int  DEF_HI  = div_pkg::DEF_HI,
    localparam int CH_W    = ch_idx_w(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iWR,
    input  logic [CH_W-1:0]   iWR_CH,
    input  logic [CNT_W-1:0]  iWR_DIV,
    input  logic [CNT_W-1:0]  iWR_HI,
    input  logic [NUM_CH-1:0] iEN,
    input  logic              iSYNC,
    output logic [NUM_CH-1:0] oDIV_CLK,
    output logic [NUM_CH-1:0] oTICK,
    output logic [NUM_CH-1:0] oPENDING
);

    logic [NUM_CH-1:0] wr_sel;
    logic [NUM_CH-1:0] div_clk_raw;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // Out-of-range indices match no channel and are dropped here.
            assign wr_sel[gi] = iWR && (iWR_CH == CH_W'(gi));

            div_channel #(
                .CNT_W   (CNT_W),
                .DEF_DIV (DEF_DIV),
                .DEF_HI  (DEF_HI)
            ) u_channel (
                .CLK      (CLK),
                .RST      (RST),
                .iWR      (wr_sel[gi]),
                .iWR_DIV  (iWR_DIV),
                .iWR_HI   (iWR_HI),
                .iEN      (iEN[gi]),
                .iSYNC    (iSYNC),
                .oDIV_CLK (div_clk_raw[gi]),
                .oTICK    (oTICK[gi]),
                .oPENDING (oPENDING[gi])
            );

`ifdef DIV_BUFG_EN
            BUFG u_bufg (
                .I (div_clk_raw[gi]),
                .O (oDIV_CLK[gi])
            );
`else
            assign oDIV_CLK[gi] = div_clk_raw[gi];
`endif
        end
    endgenerate

endmodule : multi_clk_divider
